// File: rtl/multi_mem_reader.sv
// Lockstep strided reader over NUM_CH synchronous-read memories feeding a valid/ready stream.
// Optional abort/aborted ports are enabled by defining MULTI_MEM_READER_ABORT_EN.
module multi_mem_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned LEN_WIDTH  = 5,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [ADDR_WIDTH-1:0]          stride,
  input  logic [LEN_WIDTH-1:0]           length,
`ifdef MULTI_MEM_READER_ABORT_EN
  input  logic                           abort,
  output logic                           aborted,
`endif
  output logic                           busy,
  output logic                           done,
  output logic [NUM_CH-1:0]              rd_en,
  output logic [NUM_CH*ADDR_WIDTH-1:0]   rd_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_CH*DATA_WIDTH-1:0]   out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic [LEN_WIDTH-1:0]           element_count
);

  if (RD_LATENCY != 1) begin : g_bad_latency
    $error("multi_mem_reader supports RD_LATENCY == 1 only");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t                       state_q, state_d;
  logic [LEN_WIDTH-1:0]         len_q, iss_q, elem_q;
  logic [ADDR_WIDTH-1:0]        stride_q, addr_q;
  logic [NUM_CH*DATA_WIDTH-1:0] fifo_q [2];
  logic                         wptr_q, rptr_q;
  logic [1:0]                   cnt_q, cnt_d;
  logic                         inflight_q;
  logic                         pop, push, fifo_pop, can_issue, abort_hit;
  logic [2:0]                   total;

`ifdef MULTI_MEM_READER_ABORT_EN
  logic abt_q;
  assign abort_hit = abort && (state_q == ISSUE || state_q == DRAIN);
  assign aborted   = (state_q == FIN) && abt_q;
`else
  assign abort_hit = 1'b0;
`endif

  // Returning data bypasses the FIFO when it is empty, giving one-cycle read-to-valid.
  assign out_valid     = (cnt_q != 2'd0) || inflight_q;
  assign out_data      = (cnt_q != 2'd0) ? fifo_q[rptr_q] : (inflight_q ? rd_data : '0);
  assign pop           = out_valid && out_ready;
  assign fifo_pop      = pop && (cnt_q != 2'd0);
  assign push          = inflight_q && !(cnt_q == 2'd0 && pop) && !abort_hit;
  assign total         = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
  assign can_issue     = (state_q == ISSUE) && (total < 3'd2) && !abort_hit;
  assign rd_en         = {NUM_CH{can_issue}};
  assign rd_addr       = {NUM_CH{addr_q}};
  assign busy          = (state_q == ISSUE) || (state_q == DRAIN);
  assign done          = (state_q == FIN);
  assign element_count = elem_q;
  assign out_last      = out_valid && (elem_q == len_q - LEN_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = abort_hit ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, fifo_pop};
    case (state_q)
      IDLE:    if (start) state_d = (length != '0) ? ISSUE : FIN;
      ISSUE: begin
        if (abort_hit) state_d = FIN;
        else if (can_issue && iss_q == len_q - LEN_WIDTH'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort_hit || total == 3'd0) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      len_q      <= '0;
      iss_q      <= '0;
      elem_q     <= '0;
      stride_q   <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= can_issue;
      if (push) begin
        fifo_q[wptr_q] <= rd_data;
        wptr_q         <= ~wptr_q;
      end
      if (fifo_pop) rptr_q <= ~rptr_q;
      if (abort_hit) begin
        wptr_q <= 1'b0;
        rptr_q <= 1'b0;
      end
      if (state_q == IDLE && start) begin
        len_q    <= length;
        stride_q <= stride;
        addr_q   <= base_addr;
        iss_q    <= '0;
        elem_q   <= '0;
      end else begin
        if (can_issue) begin
          addr_q <= addr_q + stride_q;
          iss_q  <= iss_q + LEN_WIDTH'(1);
        end
        if (pop) elem_q <= elem_q + LEN_WIDTH'(1);
      end
    end
  end

`ifdef MULTI_MEM_READER_ABORT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 abt_q <= 1'b0;
    else if (abort_hit)         abt_q <= 1'b1;
    else if (state_q == FIN)    abt_q <= 1'b0;
  end
`endif

endmodule
